cflog_slice_reader: RTL and testbench

CFLOG_SLICE_READER -- requirements
Module: cflog_slice_reader

---
 rtl/cflog_slice_reader.sv | 89 ++++++++
 tb/tb_cflog_slice_reader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cflog_slice_reader.sv
// cflog_slice_reader: streams a wrapped slice of the 16-bit CFLog RAM to a tx port and waits for verifier ack
module cflog_slice_reader #(
  parameter logic [15:0] LOG_SIZE = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [15:0] top_slice,
  input  logic [15:0] bottom_slice,
  output logic        log_rd_en,
  output logic [15:0] log_rd_addr,
  input  logic [15:0] log_rd_data,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  input  logic        vrf_ack,
  output logic        busy,
  output logic        slice_sent,
  output logic [15:0] sent_count,
  output logic        overrun
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_addr;
  logic [15:0] r_bot;
  logic [16:0] w_inc;
  logic [15:0] w_next;

  // 17-bit step so the wrap compare cannot overflow when LOG_SIZE is near 16'hFFFF
  assign w_inc  = {1'b0, r_addr} + 17'd2;
  assign w_next = (w_inc >= {1'b0, LOG_SIZE}) ? 16'h0000 : w_inc[15:0];

  assign busy        = r_state != S_IDLE;
  assign log_rd_en   = r_state == S_RD;
  assign log_rd_addr = r_addr;

  // slice FSM: latch bounds, read one word, present it, advance with wrap, then wait for the verifier
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= 16'h0000;
      r_bot      <= 16'h0000;
      tx_data    <= 16'h0000;
      tx_valid   <= 1'b0;
      tx_last    <= 1'b0;
      sent_count <= 16'h0000;
      slice_sent <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      slice_sent <= 1'b0;
      if (flush && r_state != S_IDLE) overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (flush) begin
          r_addr     <= {top_slice[15:1], 1'b0};
          r_bot      <= {bottom_slice[15:1], 1'b0};
          sent_count <= 16'h0000;
          r_state    <= S_RD;
        end
        S_RD: r_state <= S_LOAD;
        S_LOAD: begin
          tx_data  <= log_rd_data;
          tx_valid <= 1'b1;
          tx_last  <= r_addr == r_bot;
          r_state  <= S_SEND;
        end
        S_SEND: if (tx_ready) begin
          tx_valid   <= 1'b0;
          tx_last    <= 1'b0;
          sent_count <= (sent_count == 16'hFFFF) ? sent_count : sent_count + 16'd1;
          r_addr     <= tx_last ? r_addr : w_next;
          r_state    <= tx_last ? S_WAIT_ACK : S_RD;
        end
        S_WAIT_ACK: if (vrf_ack) begin
          slice_sent <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cflog_slice_reader.sv
// tb_cflog_slice_reader: directed checks of slice streaming, wrap, stalls, overrun and reset abort
module tb_cflog_slice_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] top_slice = 16'h0000;
  logic [15:0] bottom_slice = 16'h0000;
  logic        log_rd_en;
  logic [15:0] log_rd_addr;
  logic [15:0] log_rd_data = 16'h0000;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;
  logic        vrf_ack = 1'b0;
  logic        busy;
  logic        slice_sent;
  logic [15:0] sent_count;
  logic        overrun;
  int          checks = 0;
  int          failures = 0;
  int          rd_count = 0;
  int          rd_snap;

  cflog_slice_reader #(.LOG_SIZE(16'h0100)) dut (
    .clk(clk), .reset(reset), .flush(flush), .top_slice(top_slice), .bottom_slice(bottom_slice),
    .log_rd_en(log_rd_en), .log_rd_addr(log_rd_addr), .log_rd_data(log_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .vrf_ack(vrf_ack), .busy(busy), .slice_sent(slice_sent), .sent_count(sent_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // RAM model: word at byte offset a holds 16'hC000|a, returned the cycle after the strobe
  always @(posedge clk) begin
    if (log_rd_en) begin
      log_rd_data <= 16'hC000 | log_rd_addr;
      rd_count <= rd_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] t, input logic [15:0] b);
    top_slice = t;
    bottom_slice = b;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, n < 20, 1);
  endtask

  task automatic get_word(input string tag, input logic [15:0] d, input logic l);
    wait_valid(tag);
    chk({tag, "_data"}, tx_data, d);
    chk({tag, "_last"}, tx_last, l);
    @(negedge clk);
  endtask

  task automatic ack(input string tag);
    vrf_ack = 1'b1;
    @(negedge clk);
    vrf_ack = 1'b0;
    chk({tag, "_slice_sent"}, slice_sent, 1);
    chk({tag, "_idle"}, busy, 0);
    @(negedge clk);
    chk({tag, "_pulse_end"}, slice_sent, 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rd_en", log_rd_en, 0);
    chk("rst_rd_addr", log_rd_addr, 16'h0000);
    chk("rst_tx_data", tx_data, 16'h0000);
    chk("rst_count", sent_count, 16'h0000);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    @(negedge clk);

    rd_snap = rd_count;
    start(16'h0010, 16'h0016);
    chk("s1_busy", busy, 1);
    chk("s1_rd_en", log_rd_en, 1);
    chk("s1_rd_addr", log_rd_addr, 16'h0010);
    get_word("s1_w0", 16'hC010, 0);
    get_word("s1_w1", 16'hC012, 0);
    get_word("s1_w2", 16'hC014, 0);
    get_word("s1_w3", 16'hC016, 1);
    chk("s1_wait_busy", busy, 1);
    chk("s1_wait_valid", tx_valid, 0);
    chk("s1_count", sent_count, 16'd4);
    chk("s1_reads", rd_count - rd_snap, 4);
    @(negedge clk);
    chk("s1_wait_hold", busy, 1);
    ack("s1");

    start(16'h00FC, 16'h0002);
    get_word("s2_w0", 16'hC0FC, 0);
    get_word("s2_w1", 16'hC0FE, 0);
    get_word("s2_w2", 16'hC000, 0);
    get_word("s2_w3", 16'hC002, 1);
    chk("s2_count", sent_count, 16'd4);
    ack("s2");

    start(16'h0040, 16'h0041);
    get_word("s3_w0", 16'hC040, 1);
    chk("s3_wait_busy", busy, 1);
    chk("s3_count", sent_count, 16'd1);
    chk("s3_no_overrun", overrun, 0);
    vrf_ack = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    vrf_ack = 1'b0;
    flush = 1'b0;
    chk("s3_slice_sent", slice_sent, 1);
    chk("s3_idle", busy, 0);
    chk("s3_overrun_on_close", overrun, 1);
    @(negedge clk);
    chk("s3_flush_rejected", busy, 0);

    tx_ready = 1'b0;
    start(16'h0020, 16'h0022);
    wait_valid("s4_stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s4_hold_valid", tx_valid, 1);
      chk("s4_hold_data", tx_data, 16'hC020);
      chk("s4_hold_count", sent_count, 16'd0);
    end
    tx_ready = 1'b1;
    get_word("s4_w0", 16'hC020, 0);
    chk("s4_count_once", sent_count, 16'd1);
    get_word("s4_w1", 16'hC022, 1);
    chk("s4_count", sent_count, 16'd2);
    ack("s4");

    start(16'h0050, 16'h0056);
    get_word("s5_w0", 16'hC050, 0);
    tx_ready = 1'b0;
    wait_valid("s5_second");
    reset = 1'b1;
    #1;
    chk("s5_rst_valid", tx_valid, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_rd_en", log_rd_en, 0);
    chk("s5_rst_data", tx_data, 16'h0000);
    chk("s5_rst_count", sent_count, 16'h0000);
    chk("s5_rst_overrun", overrun, 0);
    rd_snap = rd_count;
    @(negedge clk);
    reset = 1'b0;
    tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("s5_no_reads", rd_count - rd_snap, 0);
    chk("s5_no_tx", tx_valid, 0);
    chk("s5_no_sent", slice_sent, 0);

    tx_ready = 1'b0;
    start(16'h0060, 16'h0062);
    chk("s6_rd_addr", log_rd_addr, 16'h0060);
    wait_valid("s6_send");
    top_slice = 16'h0080;
    bottom_slice = 16'h0080;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("s6_overrun", overrun, 1);
    tx_ready = 1'b1;
    get_word("s6_w0", 16'hC060, 0);
    get_word("s6_w1", 16'hC062, 1);
    chk("s6_count", sent_count, 16'd2);
    ack("s6");
    vrf_ack = 1'b1;
    @(negedge clk);
    vrf_ack = 1'b0;
    chk("s6_idle_ack_ignored", slice_sent, 0);
    chk("s6_idle_busy", busy, 0);
    chk("s6_overrun_sticky", overrun, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
